// File: rtl/memory_pkg.sv
// Shared definitions for the memory responder and the core controller that drives it.
package memory_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESPOND
    } mem_state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/sram_1rw.sv
// Single-port synchronous RAM with byte enables; read data appears one cycle after a read strobe.
module sram_1rw #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           sram_enable,
    input  logic                           sram_write,
    input  logic [$clog2(DEPTH_WORDS)-1:0] sram_address,
    input  logic [31:0]                    sram_write_data,
    input  logic [3:0]                     sram_byte_enable,
    output logic [31:0]                    sram_read_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (sram_enable) begin
            if (sram_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (sram_byte_enable[i]) begin
                        mem[sram_address][8*i +: 8] <= sram_write_data[8*i +: 8];
                    end
                end
            end else begin
                sram_read_data <= mem[sram_address];
            end
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Accepts one core memory request at a time, optionally stalls, performs a single SRAM
// access and returns a one-cycle completion pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request; captures it and range-checks the address
// ST_WAIT    | stall, counting down from WAIT_CYCLES-1
// ST_ACCESS  | sram_enable high for one cycle
// ST_CAPTURE | registers sram_read_data into read_data (reads only)
// ST_RESPOND | memory_valid pulse, with access_fault on out-of-range addresses
module memory_responder
    import memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           memory_enable,
    input  logic                           memory_command,
    input  logic [31:0]                    address,
    input  logic [31:0]                    write_data,
    input  logic [3:0]                     write_strobe,
    output logic                           memory_ready,
    output logic                           memory_valid,
    output logic [31:0]                    read_data,
    output logic                           access_fault,
    output logic                           sram_enable,
    output logic                           sram_write,
    output logic [$clog2(DEPTH_WORDS)-1:0] sram_address,
    output logic [31:0]                    sram_write_data,
    output logic [3:0]                     sram_byte_enable,
    input  logic [31:0]                    sram_read_data
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    mem_state_t state;
    logic [3:0] wait_count;
    logic       command_q;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];

    // The sram_* output registers double as the captured request, so they stay stable
    // for the whole access regardless of what the core does after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            wait_count       <= '0;
            command_q        <= MEM_READ;
            memory_ready     <= 1'b0;
            memory_valid     <= 1'b0;
            access_fault     <= 1'b0;
            read_data        <= '0;
            sram_enable      <= 1'b0;
            sram_write       <= 1'b0;
            sram_address     <= '0;
            sram_write_data  <= '0;
            sram_byte_enable <= '0;
        end else begin
            memory_valid <= 1'b0;
            access_fault <= 1'b0;
            sram_enable  <= 1'b0;
            sram_write   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    memory_ready <= 1'b1;
                    if (memory_ready && memory_enable) begin
                        memory_ready     <= 1'b0;
                        command_q        <= memory_command;
                        sram_address     <= address[AW+1:2];
                        sram_write_data  <= write_data;
                        sram_byte_enable <= write_strobe;
                        if (address[31:2] >= DEPTH_LIMIT) begin
                            state        <= ST_RESPOND;
                            memory_valid <= 1'b1;
                            access_fault <= 1'b1;
                            read_data    <= '0;
                        end else if (WAIT_CYCLES > 0) begin
                            state      <= ST_WAIT;
                            wait_count <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state       <= ST_ACCESS;
                            sram_enable <= 1'b1;
                            sram_write  <= memory_command;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_count == 4'd0) begin
                        state       <= ST_ACCESS;
                        sram_enable <= 1'b1;
                        sram_write  <= command_q;
                    end else begin
                        wait_count <= wait_count - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (command_q == MEM_WRITE) begin
                        state        <= ST_RESPOND;
                        memory_valid <= 1'b1;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    read_data    <= sram_read_data;
                    state        <= ST_RESPOND;
                    memory_valid <= 1'b1;
                end
                ST_RESPOND: begin
                    state        <= ST_IDLE;
                    memory_ready <= 1'b1;
                end
                default: begin
                    state        <= ST_IDLE;
                    memory_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameters SHALL be:
  - DEPTH_WORDS, default 1024, backing store size in 32-bit words.
  - WAIT_CYCLES, default 0, extra stall cycles per access (0..15).
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk  in  1  single clock.
  - reset_n  in  1  asynchronous, active-low reset.
  - memory_enable  in  1  request strobe from core, sampled only when memory_ready=1.
  - memory_command  in  1  0=read, 1=write.
  - address  in  32  byte address; bits [1:0] ignored.
  - write_data  in  32  store data.
  - write_strobe  in  4  byte enables for store.
  - memory_ready  out  1  responder idle and able to accept a request.
  - memory_valid  out  1  one-cycle completion pulse.
  - read_data  out  32  load result, valid with memory_valid.
  - access_fault  out  1  qualifies memory_valid; address out of range.
  - sram_enable  out  1  backing store access strobe.
  - sram_write  out  1  backing store write.
  - sram_address  out  $clog2(DEPTH_WORDS)  word index.
  - sram_write_data  out  32  store data.
  - sram_byte_enable  out  4  store byte enables.
  - sram_read_data  in  32  backing store data, one cycle after sram_enable with sram_write=0.

Function
REQ-003 The block SHALL implement the FSM states IDLE, WAIT, ACCESS, CAPTURE, RESPOND.
REQ-004 IDLE SHALL behave as follows:
  - memory_ready=1.
  - memory_enable=1 captures address, command, write_data and strobe into registers.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
  - Next state is RESPOND if address[31:2] >= DEPTH_WORDS (fault).
REQ-005 WAIT SHALL count down from WAIT_CYCLES-1 and go to ACCESS when the count reaches 0.
REQ-006 ACCESS SHALL assert sram_enable for exactly one cycle, with sram_write=command and the captured address, data and strobes.
  - Read: next state CAPTURE.
  - Write: next state RESPOND.
REQ-007 CAPTURE SHALL register sram_read_data into read_data; next state RESPOND.
REQ-008 RESPOND SHALL assert memory_valid=1 for one cycle with memory_ready=0; next state IDLE.
REQ-009 memory_ready SHALL be 0 in every state except IDLE, so a request cannot be re-accepted in the memory_valid cycle.
REQ-010 Latency, with enable accepted in cycle T, SHALL be:
  - Read: memory_valid in cycle T+3+WAIT_CYCLES.
  - Write: memory_valid in cycle T+2+WAIT_CYCLES.
  - Fault: memory_valid in cycle T+1, with no WAIT and no sram_enable.
REQ-011 On a fault, access_fault=1 and read_data=0 SHALL be driven during RESPOND; access_fault SHALL be 0 at all other times.
REQ-012 read_data SHALL hold its last value until the next CAPTURE or fault.
REQ-013 A write with write_strobe=4'b0000 SHALL still perform ACCESS and respond normally; the backing store is unchanged.
REQ-014 memory_enable and memory_command SHALL be ignored outside IDLE; input changes after acceptance SHALL not affect the in-flight access.
REQ-015 An address at the last word, DEPTH_WORDS-1, SHALL be legal; DEPTH_WORDS SHALL fault.

Reset
REQ-016 While reset_n=0 the block SHALL be in IDLE with these outputs:
  - memory_ready=0
  - memory_valid=0
  - access_fault=0
  - sram_enable=0
  - read_data=0
  - wait counter=0
REQ-017 memory_ready SHALL rise in the first cycle after reset_n deasserts.
REQ-018 Reset asserted mid-access SHALL abort the access immediately, with no memory_valid pulse and no further sram_enable.

Structure
REQ-019 Package memory_pkg SHALL hold the state enum and the constants MEM_READ=0 and MEM_WRITE=1 shared with the core controller.
REQ-020 The backing array SHALL be a separate module sram_1rw, a single-port synchronous RAM with byte enables, instantiated beside memory_responder; memory_responder has no sub-modules.

Verification
REQ-021 Read, WAIT_CYCLES=0, word 5 preloaded 0xDEADBEEF, enable with address 0x14 in cycle T -> memory_valid in T+3, read_data=0xDEADBEEF, memory_ready=0 in T+1..T+3.
REQ-022 Write, address 0x8, data 0x11223344, strobe 4'b0011, word 2 initially 0xAABBCCDD -> memory_valid in T+2; a subsequent read returns 0xAABB3344.
REQ-023 WAIT_CYCLES=3 read -> memory_valid in T+6; enable held high through the valid cycle -> the next access is accepted no earlier than T+7.
REQ-024 DEPTH_WORDS=1024, read at address 0x1000 -> memory_valid in T+1, access_fault=1, read_data=0, sram_enable never asserted; address 0xFFC reads normally.
REQ-025 reset_n pulsed low in the WAIT state -> no memory_valid, outputs at reset values, memory_ready=1 in the first cycle after release.
